mux_sel_stream: RTL and testbench
=================================

Name: mux_sel_stream

Overview:
- Parametrised, registered N:1 channel selector with valid/ready handshakes on every input channel and on the output.
- Successor to the team's fixed 6:1, 4-bit combinational selector. Adds configurable channel count and width, a one-deep output register stage, backpressure, an out-of-range select error flag, and a round-robin mode.
- Sits between multiple producers and a single downstream consumer.

Parameters:
- NUM_CH, 6, number of input channels (2..16).
- DATA_W, 4, data width per channel.
- SEL_W, 3, select/channel-index width; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = MODE_SELECT (use sel), 1 = MODE_RR (round-robin).
- sel  input  SEL_W  channel select, used in MODE_SELECT only.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel ready; combinational; at most one bit high.
- out_valid  output  1  output register holds data.
- out_data  output  DATA_W  registered data.
- out_ready  input  1  downstream accept.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- sel_err  output  1  registered flag: MODE_SELECT with sel >= NUM_CH.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr pointer=0. While rst=1, in_ready is all-zero.
- Load enable: can_load = !out_valid || out_ready. This gives full throughput, one transfer per cycle, with no bubble under continuous out_ready.
- Input transfer on channel k occurs when in_valid[k] && in_ready[k]. On the same edge:
  - out_data <= in_data[k]
  - out_ch <= k
  - out_valid <= 1
- Latency: input accept at edge N gives out_valid=1 after edge N, i.e. in cycle N+1.
- Output hold: if out_valid && !out_ready, out_data and out_ch hold stable and all in_ready are 0.
- Output drain: if out_valid && out_ready and no new input transfer occurs, out_valid <= 0; out_data keeps its last value.
- MODE_SELECT:
  - If sel < NUM_CH: in_ready[sel] = can_load; all others are 0.
  - If sel >= NUM_CH: all in_ready are 0, no transfer occurs, and the output register only drains.
  - sel may change every cycle; it is evaluated combinationally in the cycle of transfer.
- MODE_RR:
  - Grant = first k with in_valid[k]=1, searching ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1.
  - in_ready[grant] = can_load.
  - On a transfer from channel g: ptr <= (g == NUM_CH-1) ? 0 : g+1.
  - No valid inputs means no grant, and ptr holds.
- sel_err: sel_err <= (mode==0 && sel >= NUM_CH), one-cycle latency, level (not sticky). It is 0 in MODE_RR.
- Mode switch:
  - Takes effect the same cycle.
  - ptr is retained across mode changes and is updated only by MODE_RR transfers.
  - The output register contents are unaffected.
- Producers must hold in_data stable while in_valid && !in_ready (producer rule; the block does not check it).
- Reset mid-transfer: pending output data is discarded (out_valid=0 next cycle) and ptr returns to 0.

Decomposition:
- Package mux_sel_pkg holds:
  - mode constants MODE_SELECT=1'b0 and MODE_RR=1'b1
  - a helper function for channel-slice extraction
- Sub-module rr_arbiter (params NUM_CH, SEL_W):
  - inputs: clk, rst, req[NUM_CH], advance, adv_idx
  - outputs: grant_vld, grant_idx
  - owns the rotating pointer
- The top level holds the select/grant muxing and the output register.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=6'b000100, ch2 data=4'hA, out_ready=1 -> in_ready=6'b000100; next cycle out_valid=1, out_data=4'hA, out_ch=2.
- mode=0, sel=6 (NUM_CH=6), all in_valid=1 -> in_ready=0 every cycle; sel_err=1 from the following cycle; out_valid falls to 0 after drain.
- Backpressure: load ch1=4'h3, out_ready=0 for 3 cycles -> out_data stays 4'h3 and in_ready=0 throughout; raise out_ready -> ch1's next word accepted the same cycle, no bubble.
- MODE_RR, all six in_valid=1, out_ready=1 -> out_ch sequence 0,1,2,3,4,5,0 on consecutive cycles.
- MODE_RR, in_valid=6'b100001, ptr=1 after reset plus one ch0 transfer -> grant ch5 next, then ch0 (wrap-around).
- rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, sel_err=0; the next MODE_RR grant starts from ch0.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared mode constants and channel-slice helper for mux_sel_stream
package mux_sel_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Widest flattened channel bus the slice helper accepts.
    localparam int MAX_BUS = 512;

    // Returns channel idx of a flattened bus of w-bit channels, zero-extended to 32 bits.
    function automatic logic [31:0] ch_slice(input logic [MAX_BUS-1:0] bus, input int idx, input int w);
        return 32'(bus >> (idx * w)) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority request arbiter that owns the round-robin pointer
//   clk, rst            : clock, synchronous active-high reset (pointer -> 0)
//   req[NUM_CH]         : per-channel requests
//   advance, adv_idx    : a transfer from channel adv_idx moves the pointer past it
//   grant_vld, grant_idx: first requesting channel at or after the pointer (wrapping)
module rr_arbiter #(
    parameter int NUM_CH = 6,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    input  logic [SEL_W-1:0]  adv_idx,
    output logic              grant_vld,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] r_ptr;

    // Scan from the farthest offset down to the pointer so the closest requester wins.
    always_comb begin
        logic [SEL_W-1:0] w_k;
        w_k       = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_k = SEL_W'((int'(r_ptr) + i) % NUM_CH);
            if (req[w_k]) begin
                grant_vld = 1'b1;
                grant_idx = w_k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (advance)
            r_ptr <= (adv_idx == SEL_W'(NUM_CH - 1)) ? '0 : adv_idx + 1'b1;
    end

endmodule

// File: rtl/mux_sel_stream.sv
// mux_sel_stream: registered N:1 valid/ready channel selector with select and round-robin modes
//   clk, rst      : clock, synchronous active-high reset
//   mode, sel     : 0 = take channel sel, 1 = round-robin over valid channels
//   in_valid/in_data/in_ready : per-channel handshake, channel k at in_data[k*DATA_W +: DATA_W]
//   out_valid/out_data/out_ch/out_ready : one-deep registered output and source channel
//   sel_err       : registered flag for an out-of-range sel in select mode
module mux_sel_stream
    import mux_sel_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 4,
    parameter int SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     sel_err
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_sel_err;

    logic              w_can_load;
    logic              w_sel_ok;
    logic              w_grant_vld;
    logic [SEL_W-1:0]  w_grant_idx;
    logic              w_ch_vld;
    logic [SEL_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_data;
    logic              w_xfer;

    rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (in_valid),
        .advance  (w_xfer && mode == MODE_RR),
        .adv_idx  (w_grant_idx),
        .grant_vld(w_grant_vld),
        .grant_idx(w_grant_idx)
    );

    // Select mode offers ready to sel regardless of its valid; RR only to the granted requester.
    always_comb begin
        w_can_load = !r_out_valid || out_ready;
        w_sel_ok   = 32'(sel) < NUM_CH;
        w_ch_vld   = (mode == MODE_RR) ? w_grant_vld : w_sel_ok;
        w_idx      = (mode == MODE_RR) ? w_grant_idx : sel;
        in_ready   = (w_can_load && w_ch_vld && !rst) ? NUM_CH'(1) << w_idx : '0;
        w_xfer     = |(in_ready & in_valid);
        w_data     = DATA_W'(ch_slice(MAX_BUS'(in_data), int'(w_idx), DATA_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_sel_err <= (mode == MODE_SELECT) && !w_sel_ok;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_ch    <= w_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_sel_stream.sv
// tb_mux_sel_stream: scoreboard bench for mux_sel_stream against a queue-based reference model
module tb_mux_sel_stream;

    localparam int N = 6;
    localparam int W = 4;
    localparam int S = 3;

    typedef struct packed {
        logic [W-1:0] d;
        logic [S-1:0] c;
    } item_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [S-1:0]   sel = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready = 1'b0;
    logic [S-1:0]   out_ch;
    logic           sel_err;

    int    checks = 0;
    int    errors = 0;
    item_t q[$];
    item_t pend;
    bit    pend_vld = 0;
    int    ptr_m = 0;
    bit    exp_err = 0;

    mux_sel_stream #(.NUM_CH(N), .DATA_W(W), .SEL_W(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected in_ready from the rules: output slot free, then sel or first valid from ptr.
    function automatic logic [N-1:0] exp_ready();
        int k;
        if (q.size() != 0 && !out_ready) return '0;
        if (mode == 1'b0) return (int'(sel) < N) ? N'(1) << sel : '0;
        for (int o = 0; o < N; o++) begin
            k = (ptr_m + o) % N;
            if (in_valid[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    // One cycle: commit last edge's transfer, check sel_err, drive, then predict this cycle.
    task automatic step(input logic m, input logic [S-1:0] s, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input logic ordy);
        logic [N-1:0] er;
        logic [N-1:0] xr;
        @(posedge clk);
        #1;
        if (pend_vld) q.push_back(pend);
        pend_vld = 0;
        chk("sel_err", 32'(sel_err), 32'(exp_err));
        mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        #2;
        er = exp_ready();
        chk("in_ready", 32'(in_ready), 32'(er));
        xr = er & in_valid;
        for (int k = 0; k < N; k++) begin
            if (xr[k]) begin
                pend.d   = in_data[k*W +: W];
                pend.c   = S'(k);
                pend_vld = 1;
                if (mode) ptr_m = (k + 1) % N;
            end
        end
        exp_err = (mode == 1'b0) && (int'(sel) >= N);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; pend_vld = 0; q.delete();
        in_valid = '1; mode = 1'b1; out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_in_ready2", 32'(in_ready), 32'd0);
        rst = 1'b0; in_valid = '0; mode = 1'b0; sel = '0;
        ptr_m = 0; exp_err = 0;
    endtask

    // Monitor: the output register must present exactly the oldest accepted, unconsumed word.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(q[0].d));
                chk("out_ch", 32'(out_ch), 32'(q[0].c));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    function automatic logic [N*W-1:0] rnd_data();
        return N*W'($urandom);
    endfunction

    initial begin
        do_reset();

        // Select ch2 with data A.
        step(1'b0, 3'd2, 6'b000100, 24'h000A00, 1'b1);
        step(1'b0, 3'd2, 6'b000000, 24'h0, 1'b1);
        chk("sel2_data", 32'(out_data), 32'hA);
        chk("sel2_ch", 32'(out_ch), 32'd2);

        // Out-of-range select: nothing accepted, error flag raised, output drains.
        repeat (4) step(1'b0, 3'd6, 6'b111111, rnd_data(), 1'b1);
        chk("sel6_err", 32'(sel_err), 32'd1);

        // Backpressure on ch1 then release with ch1's next word ready the same cycle.
        step(1'b0, 3'd1, 6'b000010, 24'h000030, 1'b1);
        repeat (3) step(1'b0, 3'd1, 6'b000010, 24'h000050, 1'b0);
        chk("bp_hold", 32'(out_data), 32'h3);
        step(1'b0, 3'd1, 6'b000010, 24'h000050, 1'b1);
        step(1'b0, 3'd1, 6'b000000, 24'h0, 1'b1);
        chk("bp_next", 32'(out_data), 32'h5);

        // Round robin over all six channels from ptr 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'd0, 6'b111111, rnd_data(), 1'b1);
            if (i > 0) chk("rr_seq", 32'(out_ch), 32'((i - 1) % N));
        end

        // Wrap-around: ptr 1 with only ch0 and ch5 valid grants ch5 then ch0.
        do_reset();
        step(1'b1, 3'd0, 6'b000001, rnd_data(), 1'b1);
        step(1'b1, 3'd0, 6'b100001, rnd_data(), 1'b1);
        chk("wrap_a", 32'(out_ch), 32'd0);
        step(1'b1, 3'd0, 6'b100001, rnd_data(), 1'b1);
        chk("wrap_b", 32'(out_ch), 32'd5);
        step(1'b1, 3'd0, 6'b000000, rnd_data(), 1'b1);
        chk("wrap_c", 32'(out_ch), 32'd0);

        // Reset while output held under backpressure, then RR restarts at ch0.
        step(1'b1, 3'd0, 6'b111111, rnd_data(), 1'b0);
        step(1'b1, 3'd0, 6'b111111, rnd_data(), 1'b0);
        do_reset();
        step(1'b1, 3'd0, 6'b111111, rnd_data(), 1'b1);
        step(1'b1, 3'd0, 6'b000000, rnd_data(), 1'b1);
        chk("rst_rr_ch0", 32'(out_ch), 32'd0);

        // Randomized traffic with sticky-ish mode and occasional reset.
        begin
            logic m;
            m = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) m = ~m;
                if ($urandom_range(0, 299) == 0) do_reset();
                step(m, S'($urandom_range(0, 7)), N'($urandom), rnd_data(),
                     $urandom_range(0, 3) != 0);
            end
        end

        // Drain anything left and confirm the scoreboard empties.
        repeat (3) step(1'b0, 3'd7, 6'b000000, 24'h0, 1'b1);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
